// File: rtl/gpr_sb_regfile.sv
// Multi-read-port register file with optional zero register, write bypass,
// per-register busy scoreboard and a sequential clear engine.
module gpr_sb_regfile #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREG    = 32,
    parameter int unsigned NRD     = 2,
    parameter bit          ZERO_R0 = 1'b1,
    parameter bit          BYPASS  = 1'b1,
    localparam int unsigned AW     = $clog2(NREG)
) (
    input  logic                WrClk,
    input  logic                rst,
    input  logic                RegWr,
    input  logic [AW-1:0]       Rw,
    input  logic [XLEN-1:0]     busW,
    input  logic [NRD*AW-1:0]   Ra,
    output logic [NRD*XLEN-1:0] busR,
    output logic [NRD-1:0]      rdBusy,
    input  logic                SbSet,
    input  logic [AW-1:0]       SbRd,
    input  logic                flush,
    input  logic                clrReq,
    output logic                clrBusy
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [XLEN-1:0]   gpr_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;

    logic idle;
    logic wr_en;
    logic sb_en;
    logic start_clr;

    assign idle      = (state_q == StIdle);
    assign wr_en     = RegWr && idle && !(ZERO_R0 && (Rw == '0));
    assign sb_en     = SbSet && idle && !(ZERO_R0 && (SbRd == '0));
    assign start_clr = idle && clrReq;
    assign clrBusy   = (state_q == StClear);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (clrReq) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            StClear: begin
                if (idx_q == AW'(NREG - 1)) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // A new producer (SbSet) outranks a same-cycle writeback to the same register.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) busy_d[Rw] = 1'b0;
        if (sb_en) busy_d[SbRd] = 1'b1;
        if (flush || start_clr) busy_d = '0;
    end

    always_ff @(posedge WrClk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy_q  <= '0;
            gpr_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            if (clrBusy) begin
                gpr_q[idx_q] <= '0;
            end else if (wr_en) begin
                gpr_q[Rw] <= busW;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          zero_hit;
        logic          byp_hit;

        assign ra       = Ra[i*AW +: AW];
        assign zero_hit = ZERO_R0 && (ra == '0);
        assign byp_hit  = BYPASS && wr_en && (Rw == ra);
        assign busR[i*XLEN +: XLEN] = zero_hit ? '0 : (byp_hit ? busW : gpr_q[ra]);
        assign rdBusy[i] = busy_q[ra] && !zero_hit && !byp_hit;
    end

endmodule

// File: tb/tb_gpr_sb_regfile.sv
// Bench for gpr_sb_regfile: directed scenarios plus random traffic against an
// array-based reference model, on a default instance and a no-zero/no-bypass instance.
module tb_gpr_sb_regfile;

    logic        WrClk = 1'b0;
    logic        rst;
    logic        RegWr;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [9:0]  Ra;
    logic        SbSet;
    logic [4:0]  SbRd;
    logic        flush;
    logic        clrReq;

    logic [63:0] busR_a, busR_b;
    logic [1:0]  rdBusy_a, rdBusy_b;
    logic        clrBusy_a, clrBusy_b;

    int errors = 0;
    int checks = 0;

    // Reference state: inst 0 = zero-reg + bypass, inst 1 = neither.
    logic [31:0] m_regs [2][32];
    bit          m_busy [2][32];
    bit          m_clr;
    int          m_left;

    always #5 WrClk = ~WrClk;

    gpr_sb_regfile dut_a (
        .WrClk(WrClk), .rst(rst), .RegWr(RegWr), .Rw(Rw), .busW(busW), .Ra(Ra),
        .busR(busR_a), .rdBusy(rdBusy_a), .SbSet(SbSet), .SbRd(SbRd), .flush(flush),
        .clrReq(clrReq), .clrBusy(clrBusy_a)
    );

    gpr_sb_regfile #(.ZERO_R0(1'b0), .BYPASS(1'b0)) dut_b (
        .WrClk(WrClk), .rst(rst), .RegWr(RegWr), .Rw(Rw), .busW(busW), .Ra(Ra),
        .busR(busR_b), .rdBusy(rdBusy_b), .SbSet(SbSet), .SbRd(SbRd), .flush(flush),
        .clrReq(clrReq), .clrBusy(clrBusy_b)
    );

    function automatic bit fwd(int z, logic [4:0] ra);
        return (z == 0) && RegWr && !m_clr && (Rw == ra) && (Rw != 0);
    endfunction

    function automatic logic [31:0] exp_rd(int z, logic [4:0] ra);
        if (z == 0 && ra == 0) return 32'h0;
        if (fwd(z, ra)) return busW;
        return m_regs[z][ra];
    endfunction

    function automatic logic exp_bz(int z, logic [4:0] ra);
        if (z == 0 && ra == 0) return 1'b0;
        if (fwd(z, ra)) return 1'b0;
        return m_busy[z][ra];
    endfunction

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int r = 0; r < 32; r++) begin
                m_regs[z][r] = '0;
                m_busy[z][r] = 1'b0;
            end
        m_clr  = 1'b0;
        m_left = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic tick();
        bit idle;
        idle = !m_clr;
        for (int z = 0; z < 2; z++) begin
            bit wr, sb;
            wr = RegWr && idle && !(z == 0 && Rw == 0);
            sb = SbSet && idle && !(z == 0 && SbRd == 0);
            if (m_clr) m_regs[z][32 - m_left] = '0;
            else if (wr) m_regs[z][Rw] = busW;
            if (flush || (idle && clrReq)) begin
                for (int r = 0; r < 32; r++) m_busy[z][r] = 1'b0;
            end else begin
                if (wr) m_busy[z][Rw] = 1'b0;
                if (sb) m_busy[z][SbRd] = 1'b1;
            end
        end
        if (idle && clrReq) begin
            m_clr  = 1'b1;
            m_left = 32;
        end else if (m_clr) begin
            m_left--;
            if (m_left == 0) m_clr = 1'b0;
        end
        @(posedge WrClk);
        #1;
    endtask

    task automatic idle_inputs();
        RegWr = 0; Rw = 0; busW = 0; Ra = 0; SbSet = 0; SbRd = 0; flush = 0; clrReq = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #12;
        for (int a = 0; a < 32; a++) begin
            Ra = {a[4:0], a[4:0]};
            #1;
            checks++;
            if (busR_a !== 64'h0 || busR_b !== 64'h0 || rdBusy_a !== 2'b0 || rdBusy_b !== 2'b0) begin
                errors++;
                $display("FAIL reset_read a=%0d got %h/%h busy %b/%b want 0", a, busR_a, busR_b,
                         rdBusy_a, rdBusy_b);
            end
        end
        checks++;
        if (clrBusy_a !== 1'b0 || clrBusy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_clrbusy got %b/%b want 0", clrBusy_a, clrBusy_b);
        end
        @(negedge WrClk);
        rst = 1'b0;
        @(posedge WrClk);
        #1;
    endtask

    task automatic test_write_read();
        RegWr = 1; Rw = 5; busW = 32'hDEADBEEF;
        tick();
        RegWr = 0; Ra = {5'd0, 5'd5};
        #1;
        checks++;
        if (busR_a[31:0] !== 32'hDEADBEEF || busR_a[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL write_x5 got %h want 00000000deadbeef", busR_a);
        end
        RegWr = 1; Rw = 0; busW = 32'h1234;
        tick();
        RegWr = 0; Ra = {5'd0, 5'd0};
        #1;
        checks++;
        if (busR_a[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL zero_r0 got %h want 0", busR_a[31:0]);
        end
        checks++;
        if (busR_b[31:0] !== 32'h1234) begin
            errors++;
            $display("FAIL x0_writable got %h want 1234", busR_b[31:0]);
        end
    endtask

    task automatic test_bypass();
        RegWr = 1; Rw = 7; busW = 32'h1111;
        tick();
        busW = 32'hA5A5; Ra = {5'd0, 5'd7};
        #1;
        checks++;
        if (busR_a[31:0] !== 32'hA5A5) begin
            errors++;
            $display("FAIL bypass_on got %h want a5a5", busR_a[31:0]);
        end
        checks++;
        if (busR_b[31:0] !== 32'h1111) begin
            errors++;
            $display("FAIL bypass_off got %h want 1111", busR_b[31:0]);
        end
        tick();
        RegWr = 0;
        #1;
        checks++;
        if (busR_b[31:0] !== 32'hA5A5) begin
            errors++;
            $display("FAIL bypass_off_later got %h want a5a5", busR_b[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        SbSet = 1; SbRd = 3;
        tick();
        SbSet = 0; Ra = {5'd0, 5'd3};
        #1;
        checks++;
        if (rdBusy_a[0] !== 1'b1 || rdBusy_b[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set got %b/%b want 1", rdBusy_a[0], rdBusy_b[0]);
        end
        RegWr = 1; Rw = 3; busW = 32'h33;
        #1;
        checks++;
        if (rdBusy_a[0] !== 1'b0 || rdBusy_b[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_bypass got %b/%b want 0/1", rdBusy_a[0], rdBusy_b[0]);
        end
        tick();
        RegWr = 0;
        #1;
        checks++;
        if (rdBusy_a[0] !== 1'b0 || rdBusy_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_wb_clear got %b/%b want 0", rdBusy_a[0], rdBusy_b[0]);
        end
        RegWr = 1; SbSet = 1; SbRd = 3;
        tick();
        RegWr = 0; SbSet = 0;
        #1;
        checks++;
        if (rdBusy_a[0] !== 1'b1 || rdBusy_b[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_wins got %b/%b want 1", rdBusy_a[0], rdBusy_b[0]);
        end
        flush = 1; SbSet = 1; SbRd = 3;
        tick();
        flush = 0; SbSet = 0;
        #1;
        checks++;
        if (rdBusy_a[0] !== 1'b0 || rdBusy_b[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_flush got %b/%b want 0", rdBusy_a[0], rdBusy_b[0]);
        end
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            RegWr  = ($urandom_range(1) == 1);
            Rw     = 5'($urandom_range(31));
            busW   = $urandom;
            SbSet  = ($urandom_range(2) == 0);
            SbRd   = 5'($urandom_range(31));
            flush  = ($urandom_range(19) == 0);
            clrReq = ($urandom_range(59) == 0);
            Ra     = 10'($urandom);
            if ($urandom_range(3) == 0) Ra[4:0] = Rw;
            #1;
            checks++;
            if (busR_a[31:0] !== exp_rd(0, Ra[4:0]) || busR_a[63:32] !== exp_rd(0, Ra[9:5]) ||
                busR_b[31:0] !== exp_rd(1, Ra[4:0]) || busR_b[63:32] !== exp_rd(1, Ra[9:5])) begin
                errors++;
                $display("FAIL rand_read c=%0d got %h/%h want %h%h/%h%h", c, busR_a, busR_b,
                         exp_rd(0, Ra[9:5]), exp_rd(0, Ra[4:0]),
                         exp_rd(1, Ra[9:5]), exp_rd(1, Ra[4:0]));
            end
            checks++;
            if (rdBusy_a !== {exp_bz(0, Ra[9:5]), exp_bz(0, Ra[4:0])} ||
                rdBusy_b !== {exp_bz(1, Ra[9:5]), exp_bz(1, Ra[4:0])} ||
                clrBusy_a !== m_clr || clrBusy_b !== m_clr) begin
                errors++;
                $display("FAIL rand_busy c=%0d got %b/%b clr %b want %b%b/%b%b clr %b", c,
                         rdBusy_a, rdBusy_b, clrBusy_a, exp_bz(0, Ra[9:5]), exp_bz(0, Ra[4:0]),
                         exp_bz(1, Ra[9:5]), exp_bz(1, Ra[4:0]), m_clr);
            end
            tick();
        end
        idle_inputs();
        while (m_clr) tick();
    endtask

    task automatic fill();
        RegWr = 1;
        for (int r = 1; r < 32; r++) begin
            Rw = 5'(r); busW = $urandom | 32'h1;
            tick();
        end
        RegWr = 0;
    endtask

    task automatic test_clear();
        int cnt;
        fill();
        clrReq = 1;
        tick();
        clrReq = 0;
        cnt = 0;
        while (clrBusy_a === 1'b1 && cnt < 100) begin
            cnt++;
            RegWr = 1; Rw = 5'($urandom_range(1, 31)); busW = 32'hFFFF_FFFF;
            tick();
        end
        RegWr = 0;
        checks++;
        if (cnt != 32) begin
            errors++;
            $display("FAIL clear_cycles got %0d want 32", cnt);
        end
        for (int a = 0; a < 32; a++) begin
            Ra = {a[4:0], a[4:0]};
            #1;
            checks++;
            if (busR_a !== 64'h0 || busR_b !== 64'h0) begin
                errors++;
                $display("FAIL clear_regs a=%0d got %h/%h want 0", a, busR_a, busR_b);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        fill();
        SbSet = 1; SbRd = 9;
        tick();
        SbSet = 0; clrReq = 1;
        tick();
        clrReq = 0;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (clrBusy_a !== 1'b0 || clrBusy_b !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear got %b/%b want 0", clrBusy_a, clrBusy_b);
        end
        @(negedge WrClk);
        rst = 1'b0;
        @(posedge WrClk);
        #1;
        for (int a = 0; a < 32; a++) begin
            Ra = {a[4:0], a[4:0]};
            #1;
            checks++;
            if (busR_a !== 64'h0 || busR_b !== 64'h0 || rdBusy_a !== 2'b0 || rdBusy_b !== 2'b0) begin
                errors++;
                $display("FAIL rst_mid_state a=%0d got %h/%h busy %b/%b want 0", a, busR_a,
                         busR_b, rdBusy_a, rdBusy_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_random(600);
        test_clear();
        test_random(300);
        test_reset_mid_clear();
        test_random(200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
